// File: rtl/wb_scoreboard_pkg.sv
// Shared types and constants for the writeback register-hazard scoreboard.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_scoreboard_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_IDX_W     = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Dispatcher-side description of one instruction offered for issue
  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     rs1_use;
    logic     rs2_use;
    reg_idx_t rd;
    logic     rd_we;
  } sb_iss_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue/commit/flush handshake bundle between dispatcher, committer and scoreboard.
// Latency: n/a (wires only).
// Backpressure: iss_stall flows back to the dispatcher; everything else is forward.
interface wb_scoreboard_if;
  import wb_scoreboard_pkg::*;

  logic     iss_valid;
  sb_iss_t  iss;
  logic     iss_stall;
  logic     iss_fire;
  logic     cmt_valid;
  reg_idx_t cmt_rd;
  logic     cmt_rd_we;
  logic     flush;

  modport master (
    output iss_valid, iss, iss_fire, cmt_valid, cmt_rd, cmt_rd_we, flush,
    input  iss_stall
  );

  modport slave (
    input  iss_valid, iss, iss_fire, cmt_valid, cmt_rd, cmt_rd_we, flush,
    output iss_stall
  );
endinterface

// File: rtl/sb_reg_counter.sv
// Saturating up/down counter tracking pending writers of one register (or total in-flight).
// Latency: inc/dec/clr take effect on the next clock edge; err is combinational on the event.
// Backpressure: none; saturates at 0 and MAX and flags err instead of wrapping.
module sb_reg_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         err
);

  logic at_max;
  logic at_zero;

  assign at_max  = (cnt == W'(MAX));
  assign at_zero = (cnt == '0);

  // Simultaneous inc and dec cancel; out-of-range steps hold the value
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && !at_zero) begin
      cnt <= cnt - W'(1);
    end
  end

  // Flag an attempted overflow or underflow in the cycle it is requested
  always_comb begin
    err = 1'b0;
    if (!clr) begin
      err = (inc && !dec && at_max) || (dec && !inc && at_zero);
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-hazard scoreboard gating issue into EX; optional bypass via WB_SCOREBOARD_BYPASS_EN.
// Latency: counters update on the edge after fire/commit; iss_stall is combinational from state.
// Backpressure: iss_stall on RAW hazard or when MAX_INFLIGHT reached (same-cycle commit frees a slot).
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter  int MAX_INFLIGHT = 4,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_scoreboard_if.slave           sb,
  output logic [NUM_ARCH_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]         inflight,
  output logic                     empty,
  output logic                     err
);

  logic [NUM_ARCH_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_ARCH_REGS-1:0]            cnt_err;
  logic fire_eff;
  logic cmt_eff;
  logic infl_err;
  logic illegal_fire;
  logic full;
  logic hz1;
  logic hz2;
  logic byp1;
  logic byp2;
  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;

  // A flush wins over any issue or commit in the same cycle
  assign fire_eff = sb.iss_fire && !sb.flush;
  assign cmt_eff  = sb.cmt_valid && !sb.flush;

  // x0 is hardwired zero and never tracked
  assign cnt[0]     = '0;
  assign cnt_err[0] = 1'b0;

  for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_reg
    logic inc;
    logic dec;
    assign inc = fire_eff && sb.iss.rd_we && (sb.iss.rd == REG_IDX_W'(r));
    assign dec = cmt_eff && sb.cmt_rd_we && (sb.cmt_rd == REG_IDX_W'(r));

    sb_reg_counter #(.MAX(MAX_INFLIGHT), .W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .dec (dec),
      .clr (sb.flush),
      .cnt (cnt[r]),
      .err (cnt_err[r])
    );
  end

  // Total in-flight count shares the same saturating behaviour
  sb_reg_counter #(.MAX(MAX_INFLIGHT), .W(CNT_W)) u_inflight (
    .clk (clk),
    .rst (rst),
    .inc (fire_eff),
    .dec (cmt_eff),
    .clr (sb.flush),
    .cnt (inflight),
    .err (infl_err)
  );

  assign rs1_cnt = cnt[sb.iss.rs1];
  assign rs2_cnt = cnt[sb.iss.rs2];

`ifdef WB_SCOREBOARD_BYPASS_EN
  // Last pending writer committing now: register file forwards the data
  assign byp1 = sb.cmt_valid && sb.cmt_rd_we && (sb.cmt_rd == sb.iss.rs1) &&
                (rs1_cnt == CNT_W'(1));
  assign byp2 = sb.cmt_valid && sb.cmt_rd_we && (sb.cmt_rd == sb.iss.rs2) &&
                (rs2_cnt == CNT_W'(1));
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Hazards use pre-update counters so an instruction never blocks on its own rd
  always_comb begin
    hz1  = sb.iss.rs1_use && (sb.iss.rs1 != '0) && (rs1_cnt != '0) && !byp1;
    hz2  = sb.iss.rs2_use && (sb.iss.rs2 != '0) && (rs2_cnt != '0) && !byp2;
    full = (inflight == CNT_W'(MAX_INFLIGHT)) && !sb.cmt_valid;
    sb.iss_stall = sb.iss_valid && (hz1 || hz2 || full);
  end

  // Per-register busy flags derived from the registered counters
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NUM_ARCH_REGS; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  assign empty        = (inflight == '0);
  assign illegal_fire = fire_eff && (!sb.iss_valid || sb.iss_stall);

  // Sticky error: only reset clears it, flush leaves it standing
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((|cnt_err) || infl_err || illegal_fire) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: stimulus pushes expected observations, a monitor checks them.
// Latency: expectations are tagged with the cycle they must be observed in.
// Backpressure: n/a.
module tb_wb_scoreboard;
  import wb_scoreboard_pkg::*;

`ifdef WB_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic        empty;
  logic        err;

  wb_scoreboard_if sb_if ();

  wb_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sb       (sb_if.slave),
    .busy_vec (busy_vec),
    .inflight (inflight),
    .empty    (empty),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [37:0] vec;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: compares every queued expectation in the cycle it is due
  always @(negedge clk) begin
    exp_t        e;
    logic [37:0] act;
    act = {sb_if.iss_stall, busy_vec, inflight, empty, err};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc == cyc && act === e.vec) begin
        n_pass++;
      end else begin
        $display("FAIL %s @cyc %0d: got stall=%b busy=%h infl=%0d empty=%b err=%b, want stall=%b busy=%h infl=%0d empty=%b err=%b",
                 e.name, cyc, act[37], act[36:5], act[4:2], act[1], act[0],
                 e.vec[37], e.vec[36:5], e.vec[4:2], e.vec[1], e.vec[0]);
      end
    end
  end

  task automatic idle();
    sb_if.iss_valid = 1'b0;
    sb_if.iss       = '0;
    sb_if.iss_fire  = 1'b0;
    sb_if.cmt_valid = 1'b0;
    sb_if.cmt_rd    = '0;
    sb_if.cmt_rd_we = 1'b0;
    sb_if.flush     = 1'b0;
  endtask

  task automatic iss(input bit v, input bit f, input logic [4:0] rd, input bit we,
                     input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2);
    sb_if.iss_valid   = v;
    sb_if.iss_fire    = f;
    sb_if.iss.rd      = rd;
    sb_if.iss.rd_we   = we;
    sb_if.iss.rs1     = rs1;
    sb_if.iss.rs1_use = u1;
    sb_if.iss.rs2     = rs2;
    sb_if.iss.rs2_use = u2;
  endtask

  task automatic cmt(input logic [4:0] rd, input bit we);
    sb_if.cmt_valid = 1'b1;
    sb_if.cmt_rd    = rd;
    sb_if.cmt_rd_we = we;
  endtask

  task automatic chk(input string name, input bit stall, input logic [31:0] busy,
                     input logic [2:0] infl, input bit emp, input bit er);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.vec  = {stall, busy, infl, emp, er};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, want end before 200000");
    $fatal(1);
  end

  initial begin
    logic [31:0] acc;
    int          dr[4];
    dr = '{2, 3, 4, 8};

    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset", 0, 32'h0, 0, 1, 0);
    tick();
    rst = 1'b0;

    // RAW on x5
    idle(); iss(1, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0);
    chk("a_issue", 0, 32'h0, 0, 1, 0); tick();
    idle(); iss(1, 0, 5'd6, 1, 5'd5, 1, 5'd0, 0);
    chk("a_raw_stall", 1, 32'h20, 1, 0, 0); tick();
    idle(); iss(1, BYP, 5'd6, 1, 5'd5, 1, 5'd0, 0); cmt(5'd5, 1);
    chk("a_cmt_cycle", !BYP, 32'h20, 1, 0, 0); tick();
    idle(); iss(!BYP, !BYP, 5'd6, 1, 5'd5, 1, 5'd0, 0);
    chk("a_release", 0, BYP ? 32'h40 : 32'h0, BYP ? 3'd1 : 3'd0, !BYP, 0); tick();
    idle(); cmt(5'd6, 1);
    chk("a_dep_issued", 0, 32'h40, 1, 0, 0); tick();

    // Fill to MAX_INFLIGHT
    acc = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      idle(); iss(1, 1, 5'(i), 1, 5'd0, 0, 5'd0, 0);
      chk("b_fill", 0, acc, 3'(i - 1), i == 1, 0);
      acc = acc | (32'h1 << i);
      tick();
    end
    idle(); iss(1, 0, 5'd8, 1, 5'd0, 0, 5'd0, 0);
    chk("b_full_stall", 1, 32'h1E, 4, 0, 0); tick();
    idle(); iss(1, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0); cmt(5'd1, 1);
    chk("b_full_release", 0, 32'h1E, 4, 0, 0); tick();
    acc = 32'h11C;
    for (int i = 0; i < 4; i++) begin
      idle(); cmt(5'(dr[i]), 1);
      chk("b_drain", 0, acc, 3'(4 - i), 0, 0);
      acc = acc & ~(32'h1 << dr[i]);
      tick();
    end
    idle();
    chk("b_empty", 0, 32'h0, 0, 1, 0); tick();

    // Same-register issue and commit
    idle(); iss(1, 1, 5'd7, 1, 5'd0, 0, 5'd0, 0);
    chk("c_iss", 0, 32'h0, 0, 1, 0); tick();
    idle(); iss(1, 1, 5'd7, 1, 5'd0, 0, 5'd0, 0); cmt(5'd7, 1);
    chk("c_same_cycle", 0, 32'h80, 1, 0, 0); tick();
    idle(); iss(1, 1, 5'd7, 1, 5'd0, 0, 5'd0, 0);
    chk("c_net_zero", 0, 32'h80, 1, 0, 0); tick();
    idle(); cmt(5'd7, 1);
    chk("c_two_pending", 0, 32'h80, 2, 0, 0); tick();
    idle(); cmt(5'd7, 1);
    chk("c_first_cmt", 0, 32'h80, 1, 0, 0); tick();
    idle();
    chk("c_second_cmt", 0, 32'h0, 0, 1, 0); tick();

    // x0 traffic
    idle(); iss(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1);
    chk("d_x0_issue", 0, 32'h0, 0, 1, 0); tick();
    idle(); cmt(5'd0, 1);
    chk("d_x0_counted", 0, 32'h0, 1, 0, 0); tick();
    idle();
    chk("d_x0_drained", 0, 32'h0, 0, 1, 0); tick();

    // Flush with issue and commit in the same cycle
    for (int i = 10; i <= 12; i++) begin
      idle(); iss(1, 1, 5'(i), 1, 5'd0, 0, 5'd0, 0); tick();
    end
    idle(); iss(1, 1, 5'd13, 1, 5'd0, 0, 5'd0, 0); cmt(5'd10, 1);
    sb_if.flush = 1'b1;
    chk("f_pre_flush", 0, 32'h1C00, 3, 0, 0); tick();
    idle();
    chk("f_post_flush", 0, 32'h0, 0, 1, 0); tick();

    // Underflow error, sticky across flush, cleared by reset
    idle(); cmt(5'd9, 1);
    chk("e_underflow_cyc", 0, 32'h0, 0, 1, 0); tick();
    idle(); iss(1, 1, 5'd9, 1, 5'd0, 0, 5'd0, 0);
    chk("e_err_set", 0, 32'h0, 0, 1, 1); tick();
    idle(); sb_if.flush = 1'b1;
    chk("e_before_flush", 0, 32'h200, 1, 0, 1); tick();
    idle();
    chk("e_err_sticky", 0, 32'h0, 0, 1, 1); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("e_err_reset", 0, 32'h0, 0, 1, 0); tick();

    // Illegal fire without iss_valid
    idle(); iss(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0); tick();
    idle();
    chk("g_illegal_fire", 0, 32'h8, 1, 0, 1); tick();

    tick();
    tick();

    n_checks++;
    if (err !== 1'b1) begin
      $display("FAIL h_err_hold: got err=%b, want err=1", err);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (inflight !== 3'd1) begin
      $display("FAIL h_infl_hold: got inflight=%0d, want inflight=1", inflight);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (busy_vec !== 32'h8) begin
      $display("FAIL h_busy_hold: got busy=%h, want busy=00000008", busy_vec);
    end else begin
      n_pass++;
    end

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: got no observation, want one at cyc %0d", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass != n_checks) begin
      $display("FAIL summary: got %0d passing, want %0d", n_pass, n_checks);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
